// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder cell, LSB first, WIDTH cycles per result.
// Optional macro SERIAL_ADDSUB_OVF_EN enables the signed overflow flag (ovf tied low otherwise).
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one operand bit per cycle through the full-adder cell
// DONE  | result registered, done pulse; start here chains straight into RUN
module serial_addsub #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] s_sh;
   logic [WIDTH-1:0] s_nxt;
   logic [CW-1:0]    cnt;
   logic             carry;
   logic             bit_s;
   logic             bit_c;
   logic             last;

   assign bit_s = a_sh[0] ^ b_sh[0] ^ carry;
   assign bit_c = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
   assign last  = (cnt == CW'(WIDTH - 1));

   // Sum bits enter at the MSB so the word is in place after WIDTH shifts.
   generate
      if (WIDTH == 1) begin : g_w1
         assign s_nxt = bit_s;
      end else begin : g_wn
         assign s_nxt = {bit_s, s_sh[WIDTH-1:1]};
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         sum   <= '0;
         cout  <= 1'b0;
         a_sh  <= '0;
         b_sh  <= '0;
         s_sh  <= '0;
         cnt   <= '0;
         carry <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               done <= 1'b0;
               if (start) begin
                  a_sh  <= a;
                  b_sh  <= b ^ {WIDTH{sub}};
                  carry <= sub;
                  s_sh  <= '0;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= RUN;
               end else begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            RUN: begin
               a_sh  <= a_sh >> 1;
               b_sh  <= b_sh >> 1;
               s_sh  <= s_nxt;
               carry <= bit_c;
               cnt   <= cnt + CW'(1);
               if (last) begin
                  sum   <= s_nxt;
                  cout  <= bit_c;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef SERIAL_ADDSUB_OVF_EN
   // On the final bit the carry register holds the carry into the MSB.
   logic ovf_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         ovf_q <= 1'b0;
      end else if (state == RUN && last) begin
         ovf_q <= carry ^ bit_c;
      end
   end

   assign ovf = ovf_q;
`else
   assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub: directed cases plus random operands against an arithmetic model.
// A WIDTH=1 instance covers the single-bit corner.
module tb_serial_addsub;

   logic       clk = 1'b0;
   logic       reset;
   logic       start, sub;
   logic [7:0] a, b;
   logic       busy, done, cout, ovf;
   logic [7:0] sum;

   logic       start1, sub1;
   logic [0:0] a1, b1, sum1;
   logic       busy1, done1, cout1, ovf1;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   serial_addsub #(.WIDTH(8)) u_dut (
      .clk(clk), .reset(reset), .start(start), .sub(sub), .a(a), .b(b),
      .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
   );

   serial_addsub #(.WIDTH(1)) u_dut1 (
      .clk(clk), .reset(reset), .start(start1), .sub(sub1), .a(a1), .b(b1),
      .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, want);
      end
   endtask

   // Returns {ovf, cout, sum[31:0]} from plain integer arithmetic.
   function automatic logic [33:0] ref_result(input int w, input logic [31:0] x, input logic [31:0] y,
                                              input logic s);
      logic [63:0] mask, xx, yy, full, r;
      logic        co, ov;
      mask = (64'd1 << w) - 64'd1;
      xx   = {32'b0, x} & mask;
      yy   = s ? (~{32'b0, y}) & mask : {32'b0, y} & mask;
      full = xx + yy + {63'b0, s};
      r    = full & mask;
      co   = full[w];
      ov   = 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
      ov = (xx[w-1] == yy[w-1]) && (r[w-1] != xx[w-1]);
`endif
      return {ov, co, r[31:0]};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Starts an operation in the current cycle and returns in the done cycle.
   task automatic do_op(input logic [7:0] ia, input logic [7:0] ib, input logic isub, input string tag);
      logic [33:0] e;
      logic [7:0]  held;
      int          lat, nbusy;
      bit          moved;
      e     = ref_result(8, {24'b0, ia}, {24'b0, ib}, isub);
      held  = sum;
      moved = 0;
      a = ia; b = ib; sub = isub; start = 1'b1;
      tick();
      start = 1'b0;
      a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom);
      lat = 1; nbusy = 0;
      while (!done && lat < 40) begin
         if (busy) nbusy++;
         if (sum !== held) moved = 1;
         tick();
         lat++;
      end
      check({tag, ".latency"}, lat, 9);
      check({tag, ".busy_cycles"}, nbusy, 8);
      check({tag, ".sum_held_in_run"}, {31'b0, moved}, 0);
      check({tag, ".busy_in_done"}, {31'b0, busy}, 0);
      check({tag, ".sum"}, {24'b0, sum}, {24'b0, e[7:0]});
      check({tag, ".cout"}, {31'b0, cout}, {31'b0, e[32]});
      check({tag, ".ovf"}, {31'b0, ovf}, {31'b0, e[33]});
   endtask

   task automatic idle_step(input string tag);
      tick();
      check({tag, ".done_one_cycle"}, {31'b0, done}, 0);
   endtask

   initial begin
      int          ndone, first_done;
      logic [7:0]  done_sum;
      logic [33:0] e;
      int          lat;

      reset = 1'b1; start = 1'b1; sub = 1'b0; a = 8'd55; b = 8'd66;
      start1 = 1'b1; sub1 = 1'b0; a1 = 1'b1; b1 = 1'b1;
      tick();
      tick();
      check("reset.busy", {31'b0, busy}, 0);
      check("reset.done", {31'b0, done}, 0);
      check("reset.sum", {24'b0, sum}, 0);
      check("reset.cout", {31'b0, cout}, 0);
      check("reset.ovf", {31'b0, ovf}, 0);
      check("reset.busy1", {31'b0, busy1}, 0);
      reset = 1'b0; start = 1'b0; start1 = 1'b0;
      tick();

      do_op(8'd100, 8'd27, 1'b0, "add100_27");
      idle_step("add100_27");
      do_op(8'd200, 8'd100, 1'b0, "add200_100");
      idle_step("add200_100");
      do_op(8'd5, 8'd7, 1'b1, "sub5_7");
      idle_step("sub5_7");
      do_op(8'd127, 8'd1, 1'b0, "add127_1");
      idle_step("add127_1");

      // start during RUN cycle 3 must not disturb the operation in flight
      a = 8'd50; b = 8'd20; sub = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      a = 8'd1; b = 8'd1; sub = 1'b1; start = 1'b1;
      ndone = 0; first_done = 0; done_sum = 8'd0;
      for (int cyc = 3; cyc < 25; cyc++) begin
         if (done) begin
            ndone++;
            if (first_done == 0) begin
               first_done = cyc;
               done_sum   = sum;
            end
         end
         tick();
         start = 1'b0;
      end
      check("ignore.done_count", ndone, 1);
      check("ignore.done_cycle", first_done, 9);
      check("ignore.sum", {24'b0, done_sum}, 70);

      // reset in RUN cycle 4 aborts without a done pulse
      a = 8'd9; b = 8'd9; sub = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("abort.busy", {31'b0, busy}, 0);
      check("abort.sum", {24'b0, sum}, 0);
      ndone = 0;
      for (int cyc = 0; cyc < 12; cyc++) begin
         if (done) ndone++;
         tick();
      end
      check("abort.no_done", ndone, 0);
      do_op(8'd1, 8'd1, 1'b0, "after_abort");
      idle_step("after_abort");

      // back-to-back: start held in the DONE cycle
      do_op(8'd100, 8'd27, 1'b0, "b2b_first");
      do_op(8'd10, 8'd3, 1'b1, "b2b_second");
      idle_step("b2b_second");

      for (int i = 0; i < 24; i++) begin
         do_op(8'($urandom), 8'($urandom), 1'($urandom), $sformatf("rand%0d", i));
         if ($urandom_range(1, 0) == 1) idle_step($sformatf("rand%0d", i));
      end

      for (int i = 0; i < 8; i++) begin
         a1 = 1'(i); b1 = 1'(i >> 1); sub1 = 1'(i >> 2);
         e = ref_result(1, {31'b0, a1}, {31'b0, b1}, sub1);
         start1 = 1'b1;
         tick();
         start1 = 1'b0;
         lat = 1;
         while (!done1 && lat < 10) begin
            tick();
            lat++;
         end
         check($sformatf("w1_%0d.latency", i), lat, 2);
         check($sformatf("w1_%0d.sum", i), {31'b0, sum1}, {31'b0, e[0]});
         check($sformatf("w1_%0d.cout", i), {31'b0, cout1}, {31'b0, e[32]});
         check($sformatf("w1_%0d.ovf", i), {31'b0, ovf1}, {31'b0, e[33]});
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
